// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester sharing arbiter:
// op-code encodings, the arbiter state type and default widths.
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: add, sub, and, or, unsigned set-less-than.
// Unused op codes fall back to add; arithmetic wraps with no carry out.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the pointer picks the winner. Grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with round-robin grant, registered
// operands and per-requester response channels. Define ALU_ARB_PERF_EN for counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       stall_cnt
`endif
);

  arb_state_t        state_q, state_d;
  logic              rrPtr_q, rrPtr_d;
  logic              gid_q, gid_d;
  logic [DATA_W-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;

  logic [1:0]        grant;
  logic              isIdle, handshake, respFire;
  logic [DATA_W-1:0] aluResult;
  logic              aluZero;

  rr_arb2 u_rr_arb2 (
    .valid_i (({req1_valid, req0_valid})),
    .ptr_i   (rrPtr_q),
    .grant_o (grant)
  );

  // The ALU only ever sees the latched operands, so requesters may change inputs freely.
  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a_i      (opA_q),
    .b_i      (opB_q),
    .op_i     (op_q),
    .result_o (aluResult),
    .zero_o   (aluZero)
  );

  assign isIdle      = (state_q == ARB_IDLE);
  assign req0_ready  = isIdle & grant[0];
  assign req1_ready  = isIdle & grant[1];
  assign handshake   = isIdle & (|grant);
  assign resp0_valid = (state_q == ARB_RESP) & ~gid_q;
  assign resp1_valid = (state_q == ARB_RESP) & gid_q;
  assign respFire    = (state_q == ARB_RESP) & (gid_q ? resp1_ready : resp0_ready);
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign busy        = ~isIdle;

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    gid_d    = gid_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ARB_IDLE: begin
        if (handshake) begin
          gid_d   = grant[1];
          rrPtr_d = ~grant[1];
          opA_d   = grant[1] ? req1_a  : req0_a;
          opB_d   = grant[1] ? req1_b  : req0_b;
          op_d    = grant[1] ? req1_op : req0_op;
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        result_d = aluResult;
        zero_d   = aluZero;
        state_d  = ARB_RESP;
      end
      ARB_RESP: begin
        if (respFire) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rrPtr_q  <= 1'b0;
      gid_q    <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      gid_q    <= gid_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [15:0] grantCnt0_q, grantCnt1_q, stallCnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      grantCnt0_q <= '0;
      grantCnt1_q <= '0;
      stallCnt_q  <= '0;
    end else begin
      if (handshake && !grant[1] && grantCnt0_q != 16'hFFFF) grantCnt0_q <= grantCnt0_q + 16'd1;
      if (handshake && grant[1] && grantCnt1_q != 16'hFFFF)  grantCnt1_q <= grantCnt1_q + 16'd1;
      if (!handshake && (req0_valid || req1_valid) && stallCnt_q != 16'hFFFF)
        stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign grant_cnt0 = grantCnt0_q;
  assign grant_cnt1 = grantCnt1_q;
  assign stall_cnt  = stallCnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [15:0] resp_result;
  logic        resp_zero;
  logic        busy;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  // Model: whether an operation is outstanding, cycles since its grant,
  // who owns it, and the values the response bus should show.
  bit          mHeld;
  int          mAge;
  bit          mOwner;
  bit          mPtr;
  logic [15:0] mPending;
  logic [15:0] mResult;
  logic        mZero;
  int          mGrant0, mGrant1, mStall;

  alu_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .busy        (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    case (op)
      3'd1:    return 16'((ua + 65536 - ub) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (ua < ub) ? 16'd1 : 16'd0;
      default: return 16'((ua + ub) % 65536);
    endcase
  endfunction

  function automatic int winner();
    if (req0_valid && req1_valid) return mPtr ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic int satInc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      passCount++;
  endtask

  task automatic resetModel();
    mHeld = 0; mAge = 0; mOwner = 0; mPtr = 0;
    mPending = '0; mResult = '0; mZero = 1'b0;
    mGrant0 = 0; mGrant1 = 0; mStall = 0;
  endtask

  task automatic checkAll();
    int w;
    w = winner();
    checkOutput("req0_ready", 32'(req0_ready), 32'(!mHeld && w == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(!mHeld && w == 1));
    checkOutput("resp0_valid", 32'(resp0_valid), 32'(mHeld && mAge >= 2 && mOwner == 0));
    checkOutput("resp1_valid", 32'(resp1_valid), 32'(mHeld && mAge >= 2 && mOwner == 1));
    checkOutput("resp_result", 32'(resp_result), 32'(mResult));
    checkOutput("resp_zero", 32'(resp_zero), 32'(mZero));
    checkOutput("busy", 32'(busy), 32'(mHeld));
`ifdef ALU_ARB_PERF_EN
    checkOutput("grant_cnt0", 32'(grant_cnt0), 32'(mGrant0));
    checkOutput("grant_cnt1", 32'(grant_cnt1), 32'(mGrant1));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStall));
`endif
  endtask

  // Advances the model across one rising edge using the inputs the DUT just sampled.
  task automatic updateModel();
    int  w;
    bit  hs;
    bit  ownerReady;
    if (rst) begin
      resetModel();
      return;
    end
    w  = winner();
    hs = !mHeld && (w >= 0);
    ownerReady = mOwner ? resp1_ready : resp0_ready;
    if (hs) begin
      mGrant0 = (w == 0) ? satInc(mGrant0) : mGrant0;
      mGrant1 = (w == 1) ? satInc(mGrant1) : mGrant1;
    end else if (req0_valid || req1_valid) begin
      mStall = satInc(mStall);
    end
    if (mHeld) begin
      if (mAge == 1) begin
        mAge    = 2;
        mResult = mPending;
        mZero   = (mPending == 16'd0);
      end else if (ownerReady) begin
        mHeld = 0;
      end
    end else if (hs) begin
      mHeld    = 1;
      mAge     = 1;
      mOwner   = (w == 1);
      mPtr     = (w == 0);
      mPending = (w == 1) ? aluRef(req1_a, req1_b, req1_op) : aluRef(req0_a, req0_b, req0_op);
    end
  endtask

  task automatic applyStimulus(input logic r,
                               input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic [2:0] op0,
                               input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                               input logic [2:0] op1,
                               input logic rr0, input logic rr1);
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    resp0_ready = rr0; resp1_ready = rr1;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleCycles(input int n, input logic rr0, input logic rr1);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, rr0, rr1);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    idleCycles(2, 1'b0, 1'b0);

    $display("[TB] single request add 3+4");
    applyStimulus(1'b0, 1'b1, 16'h0003, 16'h0004, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b1);
    idleCycles(4, 1'b1, 1'b1);

    $display("[TB] contention sub 5-5 vs slt 2<9");
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, 1'b1, 16'd5, 16'd5, 3'd1, 1'b1, 16'd2, 16'd9, 3'd4, 1'b1, 1'b1);
    idleCycles(3, 1'b1, 1'b1);

    $display("[TB] backpressure on requester 1");
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h00F0, 16'h000F, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b1, 16'h1111, 16'h2222, 3'd0, 1'b1, 16'hAAAA, 16'h5555, 3'd2, 1'b1, 1'b0);
    idleCycles(3, 1'b0, 1'b1);

    $display("[TB] reset while holding a response");
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0020, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    idleCycles(3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    idleCycles(2, 1'b1, 1'b1);

    $display("[TB] wrap and default op");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b1);
    idleCycles(3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h1234, 16'h0001, 3'd7, 1'b1, 1'b1);
    idleCycles(3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0001, 3'd1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b1);
    idleCycles(3, 1'b1, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a0, b0, a1, b1;
      a0 = 16'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? a0 : 16'($urandom);
      a1 = 16'($urandom_range(0, 15));
      b1 = 16'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 63) == 0),
                    1'($urandom_range(0, 1)), a0, b0, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), a1, b1, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
